// File: rtl/raster_scroller_mc.sv
// Multi-channel tilemap raster scroll unit: per-layer shadow/active scroll registers,
// optional per-line scroll table, and a registered DW+1-bit scroll add per channel.
module raster_scroller_mc #(
  parameter int          NCH     = 2,
  parameter int          DW      = 9,
  parameter int          LINES   = 256,
  parameter int unsigned INITVAL = 0,
  localparam int         LAW     = $clog2(LINES),
  localparam int         CW      = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int         AW      = (NCH > 1) ? $clog2(NCH) + 2 : 2
) (
  input  logic                i_EMU_MCLK,
  input  logic                i_EMU_RST,
  input  logic                i_EMU_CLK6MPCEN_n,
  input  logic                i_REGEN_n,
  input  logic [AW-1:0]       i_REGADDR,
  input  logic [7:0]          i_REGDIN,
  input  logic                i_VBLANK,
  input  logic                i_HBLANK,
  input  logic [7:0]          i_VCNTR,
  input  logic [DW-1:0]       i_CNTR,
  output logic [NCH*DW-1:0]   o_SUM,
  output logic [NCH-1:0]      o_CARRY
);

  localparam logic [DW-1:0] INIT = DW'(INITVAL);

  logic          cen;
  logic [1:0]    sub;
  logic [CW-1:0] ch_sel;
  logic          ch_ok;
  logic          vb_prev, hb_prev;
  logic          vb_rise, hb_rise;
  logic          unused_vcntr;

  assign cen     = ~i_EMU_CLK6MPCEN_n;
  assign sub     = i_REGADDR[1:0];
  assign vb_rise = i_VBLANK & ~vb_prev;
  assign hb_rise = i_HBLANK & ~hb_prev;
  assign unused_vcntr = &{1'b0, i_VCNTR};

  generate
    if (NCH > 1) begin : g_multi
      assign ch_sel = i_REGADDR[AW-1:2];
      assign ch_ok  = (int'(ch_sel) < NCH);
    end else begin : g_single
      assign ch_sel = '0;
      assign ch_ok  = 1'b1;
    end
  endgenerate

  // NOTE: every clocked assignment uses <= so all registers sample pre-edge values;
  // that is what gives read-before-write and pre-write-shadow commits for free.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      vb_prev <= 1'b0;
      hb_prev <= 1'b0;
    end else if (cen) begin
      vb_prev <= i_VBLANK;
      hb_prev <= i_HBLANK;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic            wr;
    logic [DW-1:0]   shadow_q, active_q, line_q, eff;
    logic            lsen_sh_q, lsen_q, tog_q;
    logic [LAW-1:0]  ptr_q;
    logic [7:0]      lo_q;
    logic [DW:0]     sum_q;
    logic [DW-1:0]   mem [LINES];

    assign wr  = ~i_REGEN_n & ch_ok & (ch_sel == CW'(c));
    assign eff = lsen_q ? line_q : active_q;

    always_ff @(posedge i_EMU_MCLK) begin
      if (i_EMU_RST) begin
        shadow_q  <= INIT;
        active_q  <= INIT;
        lsen_sh_q <= 1'b0;
        lsen_q    <= 1'b0;
        line_q    <= '0;
        ptr_q     <= '0;
        tog_q     <= 1'b0;
        lo_q      <= '0;
        sum_q     <= '0;
      end else if (cen) begin
        if (wr) begin
          case (sub)
            2'd0: shadow_q[7:0]    <= i_REGDIN;
            2'd1: shadow_q[DW-1:8] <= i_REGDIN[DW-9:0];
            2'd2: begin
              lsen_sh_q <= i_REGDIN[0];
              if (i_REGDIN[1]) begin
                ptr_q <= '0;
                tog_q <= 1'b0;
              end
            end
            default: begin
              if (!tog_q) begin
                lo_q  <= i_REGDIN;
                tog_q <= 1'b1;
              end else begin
                ptr_q <= ptr_q + 1'b1;
                tog_q <= 1'b0;
              end
            end
          endcase
        end

        // Immediate commit takes the freshly written LSEN bit; the scroll value is pre-write.
        if (wr && sub == 2'd2 && i_REGDIN[2]) begin
          active_q <= shadow_q;
          lsen_q   <= i_REGDIN[0];
        end else if (vb_rise) begin
          active_q <= shadow_q;
          lsen_q   <= lsen_sh_q;
        end

        if (hb_rise) line_q <= mem[i_VCNTR[LAW-1:0]];

        sum_q <= {1'b0, eff} + {1'b0, i_CNTR};
      end
    end

    // NOTE: the line table has no reset branch so it maps onto plain RAM.
    always_ff @(posedge i_EMU_MCLK) begin
      if (!i_EMU_RST && cen && wr && sub == 2'd3 && tog_q)
        mem[ptr_q] <= DW'({i_REGDIN, lo_q});
    end

    assign o_SUM[c*DW +: DW] = sum_q[DW-1:0];
    assign o_CARRY[c]        = sum_q[DW];
  end

endmodule

// File: tb/tb_raster_scroller_mc.sv
// Directed bench for raster_scroller_mc (NCH=2, DW=9, LINES=4, INITVAL=0x005):
// a vector table of one-cycle records plus hand-written clock-enable sequences.
module tb_raster_scroller_mc;

  localparam int NCH   = 2;
  localparam int DW    = 9;
  localparam int LINES = 4;

  logic              clk = 1'b0;
  logic              rst, cen_n, we_n, vb, hb;
  logic [2:0]        addr;
  logic [7:0]        din, vc;
  logic [DW-1:0]     cntr;
  logic [NCH*DW-1:0] sum;
  logic [NCH-1:0]    carry;

  always #5 clk = ~clk;

  raster_scroller_mc #(
    .NCH(NCH), .DW(DW), .LINES(LINES), .INITVAL(5)
  ) dut (
    .i_EMU_MCLK(clk),
    .i_EMU_RST(rst),
    .i_EMU_CLK6MPCEN_n(cen_n),
    .i_REGEN_n(we_n),
    .i_REGADDR(addr),
    .i_REGDIN(din),
    .i_VBLANK(vb),
    .i_HBLANK(hb),
    .i_VCNTR(vc),
    .i_CNTR(cntr),
    .o_SUM(sum),
    .o_CARRY(carry)
  );

  typedef struct {
    logic       cen_n, rst, we_n;
    logic [2:0] addr;
    logic [7:0] din;
    logic       vb, hb;
    logic [7:0] vc;
    logic [8:0] cntr;
    logic [8:0] s0;
    logic       c0;
    logic [8:0] s1;
    logic       c1;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic v_cen_n, v_rst, v_we_n, input logic [2:0] v_addr,
                              input logic [7:0] v_din, input logic v_vb, v_hb,
                              input logic [7:0] v_vc, input logic [8:0] v_cntr,
                              input logic [8:0] v_s0, input logic v_c0,
                              input logic [8:0] v_s1, input logic v_c1);
    vec_t v;
    v.cen_n = v_cen_n; v.rst = v_rst; v.we_n = v_we_n; v.addr = v_addr; v.din = v_din;
    v.vb = v_vb; v.hb = v_hb; v.vc = v_vc; v.cntr = v_cntr;
    v.s0 = v_s0; v.c0 = v_c0; v.s1 = v_s1; v.c1 = v_c1;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic d_cen_n, d_rst, d_we_n, input logic [2:0] d_addr,
                       input logic [7:0] d_din, input logic d_vb, d_hb,
                       input logic [7:0] d_vc, input logic [8:0] d_cntr);
    cen_n = d_cen_n; rst = d_rst; we_n = d_we_n; addr = d_addr; din = d_din;
    vb = d_vb; hb = d_hb; vc = d_vc; cntr = d_cntr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [8:0] s0, input logic c0,
                            input logic [8:0] s1, input logic c1);
    check({tag, ".sum0"},   16'(sum[8:0]),  16'(s0));
    check({tag, ".carry0"}, 16'(carry[0]),  16'(c0));
    check({tag, ".sum1"},   16'(sum[17:9]), 16'(s1));
    check({tag, ".carry1"}, 16'(carry[1]),  16'(c1));
  endtask

  initial begin
    // cen_n rst we_n addr din vb hb vc cntr | s0 c0 s1 c1
    // Reset with the clock enable inactive, then first enabled cycle: 5 + 0x1FE.
    add(1, 1, 1, 0, 8'h00, 0, 0, 0, 9'h000, 9'h000, 0, 9'h000, 0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 9'h1FE, 9'h003, 1, 9'h003, 1);
    // ch1 shadow = 0x134 without VBLANK: output still from INITVAL.
    add(0, 0, 0, 4, 8'h34, 0, 0, 0, 9'h010, 9'h015, 0, 9'h015, 0);
    add(0, 0, 0, 5, 8'h01, 0, 0, 0, 9'h010, 9'h015, 0, 9'h015, 0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 9'h010, 9'h015, 0, 9'h015, 0);
    // ch0 reg0 write coinciding with VBLANK rise: commit takes old shadow (5).
    add(0, 0, 0, 0, 8'h10, 1, 0, 0, 9'h010, 9'h015, 0, 9'h015, 0);
    add(0, 0, 1, 0, 8'h00, 1, 0, 0, 9'h010, 9'h015, 0, 9'h144, 0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 9'h0D0, 9'h0D5, 0, 9'h004, 1);
    // Next VBLANK rise commits ch0 = 0x010.
    add(0, 0, 1, 0, 8'h00, 1, 0, 0, 9'h0D0, 9'h0D5, 0, 9'h004, 1);
    add(0, 0, 1, 0, 8'h00, 1, 0, 0, 9'h0D0, 9'h0E0, 0, 9'h004, 1);
    // Table load on ch0: pointer reset, entries 0x001, 0x002, 0x1FF, 0x000.
    add(0, 0, 0, 2, 8'h02, 0, 0, 0, 9'h000, 9'h010, 0, 9'h134, 0);
    add(0, 0, 0, 3, 8'h01, 0, 0, 0, 9'h000, 9'h010, 0, 9'h134, 0);
    add(0, 0, 0, 3, 8'h00, 0, 0, 0, 9'h000, 9'h010, 0, 9'h134, 0);
    add(0, 0, 0, 3, 8'h02, 0, 0, 0, 9'h000, 9'h010, 0, 9'h134, 0);
    add(0, 0, 0, 3, 8'h00, 0, 0, 0, 9'h000, 9'h010, 0, 9'h134, 0);
    add(0, 0, 0, 3, 8'hFF, 0, 0, 0, 9'h000, 9'h010, 0, 9'h134, 0);
    add(0, 0, 0, 3, 8'h01, 0, 0, 0, 9'h000, 9'h010, 0, 9'h134, 0);
    add(0, 0, 0, 3, 8'h00, 0, 0, 0, 9'h000, 9'h010, 0, 9'h134, 0);
    add(0, 0, 0, 3, 8'h00, 0, 0, 0, 9'h000, 9'h010, 0, 9'h134, 0);
    // LSEN + immediate commit, then HBLANK fetch of entry 2 (0x1FF + 2 wraps).
    add(0, 0, 0, 2, 8'h05, 0, 0, 0, 9'h002, 9'h012, 0, 9'h136, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 2, 9'h002, 9'h002, 0, 9'h136, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 2, 9'h002, 9'h001, 1, 9'h136, 0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 9'h000, 9'h1FF, 0, 9'h134, 0);
    // Fifth entry wraps onto entry 0; VCNTR=4 indexes entry 0 with LINES=4.
    add(0, 0, 0, 3, 8'hAA, 0, 0, 0, 9'h000, 9'h1FF, 0, 9'h134, 0);
    add(0, 0, 0, 3, 8'h00, 0, 0, 0, 9'h000, 9'h1FF, 0, 9'h134, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 4, 9'h000, 9'h1FF, 0, 9'h134, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 4, 9'h000, 9'h0AA, 0, 9'h134, 0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 9'h000, 9'h0AA, 0, 9'h134, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 1, 9'h000, 9'h0AA, 0, 9'h134, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 1, 9'h000, 9'h002, 0, 9'h134, 0);
    // Entry 1 rewritten in the same cycle it is fetched: fetch sees old 0x002.
    add(0, 0, 0, 3, 8'h55, 0, 0, 0, 9'h000, 9'h002, 0, 9'h134, 0);
    add(0, 0, 0, 3, 8'h00, 0, 1, 1, 9'h000, 9'h002, 0, 9'h134, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 1, 9'h000, 9'h002, 0, 9'h134, 0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 9'h000, 9'h002, 0, 9'h134, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 1, 9'h000, 9'h002, 0, 9'h134, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 1, 9'h000, 9'h055, 0, 9'h134, 0);
    // Low byte held, then reset: next bytes 0x33,0x01 must form entry 0 = 0x133.
    add(0, 0, 0, 3, 8'h77, 0, 0, 0, 9'h000, 9'h055, 0, 9'h134, 0);
    add(0, 1, 1, 0, 8'h00, 0, 0, 0, 9'h000, 9'h000, 0, 9'h000, 0);
    add(0, 0, 0, 3, 8'h33, 0, 0, 0, 9'h000, 9'h005, 0, 9'h005, 0);
    add(0, 0, 0, 3, 8'h01, 0, 0, 0, 9'h000, 9'h005, 0, 9'h005, 0);
    add(0, 0, 0, 2, 8'h05, 0, 0, 0, 9'h000, 9'h005, 0, 9'h005, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 0, 9'h000, 9'h000, 0, 9'h005, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 0, 9'h0CD, 9'h000, 1, 9'h0D2, 0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 9'h0CD, 9'h000, 1, 9'h0D2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cen_n, vecs[i].rst, vecs[i].we_n, vecs[i].addr, vecs[i].din,
            vecs[i].vb, vecs[i].hb, vecs[i].vc, vecs[i].cntr);
      tick();
      expect_out($sformatf("v%0d", i), vecs[i].s0, vecs[i].c0, vecs[i].s1, vecs[i].c1);
    end

    // Enable held inactive: writes, blank edges and counter changes must all be ignored.
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, logic'(i % 2), 3'(4 + (i % 4)), 8'hFF, logic'(~i[0]), logic'(~i[0]), 8'h00,
            9'($urandom_range(0, 511)));
      tick();
      expect_out($sformatf("hold%0d", i), 9'h000, 1, 9'h0D2, 0);
    end

    drive(0, 0, 1, 0, 8'h00, 0, 0, 0, 9'h0CD);
    tick();
    expect_out("reen", 9'h000, 1, 9'h0D2, 0);
    // VBLANK commit after the gated writes: ch1 shadow must still be INITVAL.
    drive(0, 0, 1, 0, 8'h00, 1, 0, 0, 9'h0CD);
    tick();
    expect_out("vb_a", 9'h000, 1, 9'h0D2, 0);
    tick();
    expect_out("vb_b", 9'h000, 1, 9'h0D2, 0);

    // Immediate commit on ch1 coinciding with a VBLANK rise.
    drive(0, 0, 0, 3'd4, 8'h20, 0, 0, 0, 9'h0CD);
    tick();
    expect_out("imm_a", 9'h000, 1, 9'h0D2, 0);
    drive(0, 0, 0, 3'd6, 8'h04, 1, 0, 0, 9'h0CD);
    tick();
    expect_out("imm_b", 9'h000, 1, 9'h0D2, 0);
    drive(0, 0, 1, 0, 8'h00, 1, 0, 0, 9'h0CD);
    tick();
    expect_out("imm_c", 9'h000, 1, 9'h0ED, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
